// File: rtl/johnson_pkg.sv
// Shared types and helpers for consumers of Johnson-counter codes.
// Widths up to MaxN bits are supported by the thermometer check.
package johnson_pkg;

    typedef enum logic {ACQUIRE, TRACK} jdec_state_t;

    localparam int unsigned MaxN = 64;

    function automatic int unsigned phase_width(input int unsigned n);
        return $clog2(2 * n);
    endfunction

    // True when v has the form 0...01...1 (including all-zero).
    function automatic logic is_low_therm(input logic [MaxN-1:0] v);
        return (v & (v + MaxN'(1))) == '0;
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson decoder: maps an N-bit code to its phase index and
// flags words that are not Johnson codewords.
module johnson_decode
    import johnson_pkg::*;
#(
    parameter int unsigned N = 8,
    localparam int unsigned PW = phase_width(N)
) (
    input  logic [N-1:0]  q,
    output logic          legal,
    output logic [PW-1:0] phase
);

    logic [N-1:0]  nq;
    logic [PW-1:0] ones;
    logic [PW:0]   upper_phase;

    assign nq = ~q;

    always_comb begin
        ones = '0;
        for (int i = 0; i < int'(N); i++) begin
            ones = ones + PW'(q[i]);
        end
    end

    // 2N may not fit in PW bits; compute one bit wider, then truncate.
    assign upper_phase = (PW + 1)'(2 * N) - {1'b0, ones};

    always_comb begin
        legal = 1'b1;
        phase = '0;
        if (q == '0) begin
            legal = 1'b1;
            phase = '0;
        end else if (q[0]) begin
            legal = is_low_therm(MaxN'(q));
            phase = ones;
        end else begin
            legal = is_low_therm(MaxN'(nq));
            phase = upper_phase[PW-1:0];
        end
    end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Registers the decoded Johnson phase, checks codeword legality and step
// continuity, and keeps a saturating error count with a sticky flag.
module johnson_phase_decoder
    import johnson_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned ERR_W = 8,
    localparam int unsigned PW = phase_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [N-1:0]     q_in,
    input  logic             clr_err,
    output logic             out_valid,
    output logic [PW-1:0]    phase,
    output logic [2*N-1:0]   phase_oh,
    output logic             wrap,
    output logic             illegal_code,
    output logic             skip_err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt
);

    jdec_state_t state_q, state_d;

    logic             dec_legal;
    logic [PW-1:0]    dec_phase;
    logic [PW-1:0]    step_phase;
    logic             is_hold, is_adv, at_last;
    logic             out_valid_d, wrap_d, illegal_d, skip_d, sticky_d;
    logic [PW-1:0]    phase_d;
    logic [2*N-1:0]   phase_oh_d;
    logic [ERR_W-1:0] err_cnt_d;
    logic             err_event;

    johnson_decode #(
        .N(N)
    ) u_decode (
        .q     (q_in),
        .legal (dec_legal),
        .phase (dec_phase)
    );

    assign at_last    = (phase == PW'(2 * N - 1));
    assign step_phase = at_last ? '0 : phase + PW'(1);
    assign is_hold    = (dec_phase == phase);
    assign is_adv     = (dec_phase == step_phase);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACQUIRE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            state_d = dec_legal ? TRACK : ACQUIRE;
        end
    end

    always_comb begin
        out_valid_d = 1'b0;
        wrap_d      = 1'b0;
        illegal_d   = 1'b0;
        skip_d      = 1'b0;
        phase_d     = phase;
        phase_oh_d  = phase_oh;
        if (in_valid) begin
            if (!dec_legal) begin
                illegal_d = 1'b1;
            end else begin
                out_valid_d = 1'b1;
                phase_d     = dec_phase;
                phase_oh_d  = (2 * N)'(1) << dec_phase;
                if (state_q == TRACK) begin
                    if (is_adv) begin
                        wrap_d = at_last;
                    end else if (!is_hold) begin
                        skip_d = 1'b1;
                    end
                end
            end
        end

        // An error in the same cycle as clr_err still counts.
        err_event = illegal_d | skip_d;
        err_cnt_d = err_cnt;
        sticky_d  = err_sticky;
        if (err_event) begin
            sticky_d  = 1'b1;
            if (clr_err) begin
                err_cnt_d = ERR_W'(1);
            end else if (err_cnt != '1) begin
                err_cnt_d = err_cnt + ERR_W'(1);
            end
        end else if (clr_err) begin
            sticky_d  = 1'b0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            phase        <= '0;
            phase_oh     <= '0;
            wrap         <= 1'b0;
            illegal_code <= 1'b0;
            skip_err     <= 1'b0;
            err_sticky   <= 1'b0;
            err_cnt      <= '0;
        end else begin
            out_valid    <= out_valid_d;
            phase        <= phase_d;
            phase_oh     <= phase_oh_d;
            wrap         <= wrap_d;
            illegal_code <= illegal_d;
            skip_err     <= skip_d;
            err_sticky   <= sticky_d;
            err_cnt      <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Bench for johnson_phase_decoder (N=8): directed scenarios plus random
// stimulus, compared against a codeword-table reference model.
module tb_johnson_phase_decoder;

    logic       clk = 1'b0;
    logic       rst, in_valid, clr_err;
    logic [7:0] q_in;

    logic        out_valid, wrap, illegal_code, skip_err, err_sticky;
    logic [3:0]  phase;
    logic [15:0] phase_oh;
    logic [7:0]  err_cnt;

    logic        out_valid2, wrap2, illegal_code2, skip_err2, err_sticky2;
    logic [3:0]  phase2;
    logic [15:0] phase_oh2;
    logic [1:0]  err_cnt2;

    always #5 clk = ~clk;

    johnson_phase_decoder #(.N(8), .ERR_W(8)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .q_in(q_in), .clr_err(clr_err),
        .out_valid(out_valid), .phase(phase), .phase_oh(phase_oh), .wrap(wrap),
        .illegal_code(illegal_code), .skip_err(skip_err), .err_sticky(err_sticky),
        .err_cnt(err_cnt)
    );

    johnson_phase_decoder #(.N(8), .ERR_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .q_in(q_in), .clr_err(clr_err),
        .out_valid(out_valid2), .phase(phase2), .phase_oh(phase_oh2), .wrap(wrap2),
        .illegal_code(illegal_code2), .skip_err(skip_err2), .err_sticky(err_sticky2),
        .err_cnt(err_cnt2)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: the 16 counter codewords in sequence order.
    int code_tab[16];
    bit m_track, m_ov, m_wrap, m_ill, m_skip, m_sticky;
    int m_phase, m_cnt8, m_cnt2;
    logic [15:0] m_oh;

    function automatic int lookup(input int qv);
        for (int k = 0; k < 16; k++) if (code_tab[k] == qv) return k;
        return -1;
    endfunction

    task automatic model_step(input bit r, input bit v, input int qv, input bit c);
        int p;
        if (r) begin
            m_track = 0; m_ov = 0; m_wrap = 0; m_ill = 0; m_skip = 0; m_sticky = 0;
            m_phase = 0; m_oh = '0; m_cnt8 = 0; m_cnt2 = 0;
            return;
        end
        m_ov = 0; m_wrap = 0; m_ill = 0; m_skip = 0;
        if (v) begin
            p = lookup(qv);
            if (p < 0) begin
                m_ill = 1;
                m_track = 0;
            end else begin
                if (m_track) begin
                    if (p == (m_phase + 1) % 16) m_wrap = (m_phase == 15);
                    else if (p != m_phase) m_skip = 1;
                end
                m_phase = p;
                m_oh = 16'(1) << p;
                m_ov = 1;
                m_track = 1;
            end
        end
        if (m_ill || m_skip) begin
            m_sticky = 1;
            m_cnt8 = c ? 1 : (m_cnt8 < 255 ? m_cnt8 + 1 : 255);
            m_cnt2 = c ? 1 : (m_cnt2 < 3 ? m_cnt2 + 1 : 3);
        end else if (c) begin
            m_sticky = 0; m_cnt8 = 0; m_cnt2 = 0;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check("out_valid", 64'(out_valid), 64'(m_ov));
        check("phase", 64'(phase), 64'(m_phase));
        check("phase_oh", 64'(phase_oh), 64'(m_oh));
        check("wrap", 64'(wrap), 64'(m_wrap));
        check("illegal_code", 64'(illegal_code), 64'(m_ill));
        check("skip_err", 64'(skip_err), 64'(m_skip));
        check("err_sticky", 64'(err_sticky), 64'(m_sticky));
        check("err_cnt", 64'(err_cnt), 64'(m_cnt8));
        check("err_cnt_w2", 64'(err_cnt2), 64'(m_cnt2));
        check("err_sticky_w2", 64'(err_sticky2), 64'(m_sticky));
    endtask

    task automatic cycle(input bit r, input bit v, input logic [7:0] qq, input bit c);
        @(negedge clk);
        rst = r; in_valid = v; q_in = qq; clr_err = c;
        @(posedge clk);
        model_step(r, v, int'(qq), c);
        #1;
        check_all();
    endtask

    int wraps;
    int sel;
    logic [7:0] qr;

    initial begin
        for (int k = 0; k < 16; k++)
            code_tab[k] = (k <= 8) ? ((1 << k) - 1) : (8'hFF & ~((1 << (k - 8)) - 1));
        rst = 1; in_valid = 0; q_in = '0; clr_err = 0;

        // Reset state
        cycle(1, 0, 8'h00, 0);
        check("reset_phase_oh", 64'(phase_oh), 64'h0);

        // Full sweep 0..15 then 0
        cycle(0, 0, 8'h00, 0);
        wraps = 0;
        for (int k = 0; k <= 16; k++) begin
            cycle(0, 1, 8'(code_tab[k % 16]), 0);
            wraps += int'(wrap);
            check("sweep_onehot", 64'($onehot(phase_oh)), 64'(1));
        end
        check("sweep_wraps", 64'(wraps), 64'(1));
        check("sweep_err_cnt", 64'(err_cnt), 64'(0));

        // Hold at phase 3
        cycle(0, 1, 8'h01, 0);
        cycle(0, 1, 8'h03, 0);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 1, 8'h07, 0);
            check("hold_phase", 64'(phase), 64'(3));
        end

        // Illegal code at phase 4, then re-acquire
        cycle(0, 1, 8'h0F, 0);
        cycle(0, 1, 8'h05, 0);
        check("illegal_hold_phase", 64'(phase), 64'(4));
        cycle(0, 1, 8'h0F, 0);
        check("reacquire_no_skip", 64'(skip_err), 64'(0));

        // Skip from phase 2 to 6
        cycle(0, 1, 8'h03, 0);
        cycle(0, 1, 8'h3F, 0);
        check("skip_phase", 64'(phase), 64'(6));

        // Saturation and clear
        cycle(0, 0, 8'h00, 1);
        for (int k = 0; k < 5; k++) cycle(0, 1, 8'h05, 0);
        check("sat_w2", 64'(err_cnt2), 64'(3));
        cycle(0, 1, 8'h05, 1);
        check("clr_with_event", 64'(err_cnt2), 64'(1));
        cycle(0, 0, 8'h00, 1);
        check("clr_alone", 64'(err_cnt2), 64'(0));

        // Reset mid-sweep at phase 9, resume at phase 10
        for (int k = 0; k <= 9; k++) cycle(0, 1, 8'(code_tab[k]), 0);
        cycle(1, 1, 8'hFC, 1);
        check("rst_mid_phase", 64'(phase), 64'(0));
        cycle(0, 1, 8'hFC, 0);
        check("post_rst_phase", 64'(phase), 64'(10));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 40)      qr = 8'(code_tab[(m_phase + 1) % 16]);
            else if (sel < 55) qr = 8'(code_tab[m_phase]);
            else if (sel < 70) qr = 8'(code_tab[$urandom_range(0, 15)]);
            else               qr = 8'($urandom_range(0, 255));
            cycle(($urandom_range(0, 49) == 0), (sel < 88), qr, ($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
